multi_rate_timer: RTL and testbench
===================================

Name: multi_rate_timer

Overview:
- Bank of independent programmable period timers: the parametrised successor of the game's single flash-rate timer.
- Each channel derives its period from CLK_HZ/BASE_HZ and a per-channel speed code.
- Each channel runs periodic or one-shot, can be paused without losing its count, and counts its emitted pulses.
- Sits between the FSM (loads, pauses) and the colour-flash and input-timeout logic (consume pulses).

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
BASE_HZ, 1, slowest pulse rate (speed code 0)
CHANNELS, 2, number of independent timer channels
SPEED_W, 3, width of each channel's speed code
MAX_SHIFT, 4, highest speed code that doubles the rate; codes above it select FAST_TICKS
FAST_TICKS, 4, period in cycles for speed codes > MAX_SHIFT; must be >= 2

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
load  input  CHANNELS  per-channel start/restart strobe
speed  input  CHANNELS*SPEED_W  per-channel speed code; channel i uses bits [i*SPEED_W +: SPEED_W]
mode  input  CHANNELS  per-channel mode, sampled with load: 0 periodic, 1 one-shot
pause  input  CHANNELS  per-channel level hold; freezes the count while high
pulse  output  CHANNELS  one-cycle registered expiry strobe
active  output  CHANNELS  channel in RUN or PAUSED
pulse_cnt  output  CHANNELS*8  per-channel 8-bit pulse counter, wraps 255->0; channel i at [i*8 +: 8]

Behaviour:
- Period P(s) = (CLK_HZ/BASE_HZ) >> s for s <= MAX_SHIFT, else FAST_TICKS.
- Elaboration constraints:
  - CLK_HZ/BASE_HZ divisible by 2^MAX_SHIFT.
  - P(MAX_SHIFT) >= 2.
  - Counter width = $clog2(CLK_HZ/BASE_HZ).
- Per-channel FSM states: IDLE, RUN, PAUSED.
- Reset: all channels IDLE; counter, latched speed, latched mode, pulse, pulse_cnt all 0; active 0.
  - Reset mid-run aborts with no pulse on that edge.
- load[i] high at an edge, from any state:
  - counter <= P(speed_i)-1.
  - Latch speed_i and mode_i.
  - pulse_cnt_i <= 0; state <= RUN.
  - load has priority over pause and over expiry: no pulse on that edge.
- RUN with pause[i] high: state <= PAUSED. Counter holds; no decrement and no expiry on that edge.
- PAUSED: counter holds. When pause[i] is low, state <= RUN and decrement resumes from the next edge.
- RUN, pause low, counter != 0: counter decrements.
- RUN, pause low, counter == 0 (expiry):
  - pulse_i <= 1 for exactly one cycle; pulse_cnt_i increments (wrapping).
  - Periodic: counter reloads P(latched speed)-1 and stays in RUN.
  - One-shot: state <= IDLE on the same edge, so active falls with the pulse.
- Changing speed or mode without load has no effect until the next load.
- Latency: with load sampled at edge 0, pulse is high in the cycle after edges P, 2P, 3P, … (periodic). Exactly P cycles between pulses; every pause-high cycle in RUN/PAUSED adds one cycle.
- IDLE: counter holds; pulse stays 0; pause is ignored.
- Channels are fully independent; simultaneous events on different channels do not interact.

Test Plan:
Use CLK_HZ=64, BASE_HZ=1, MAX_SHIFT=4, FAST_TICKS=2, CHANNELS=2, so P = 64/32/16/8/4 and codes 5–7 give 2.
1. Reset, no load for 200 cycles -> pulse=0, active=0, pulse_cnt=0 throughout.
2. Ch0 load, speed=0, mode=0 at edge 0 -> pulse0 after edges 64, 128, 192; pulse_cnt0 = 1, 2, 3; active0 stays 1.
3. Ch1 load, speed=3, mode=1 at edge 0 -> single pulse1 after edge 8; active1 falls at edge 8; no pulse through edge 100; pulse_cnt1 = 1.
4. Ch0 speed=2 periodic, pause0 high for edges 5–14 (10 cycles) -> first pulse after edge 26, next after edge 42.
5. Ch0 speed=1 periodic, re-load speed=7 at edge 32 (the expiry edge) -> no pulse at 32; pulses after edges 34, 36; pulse_cnt0 restarts at 1. Then reset at edge 37 -> all outputs 0 at edge 37, no pulse after.
6. Both channels loaded at edge 0 (ch0 speed=4, ch1 speed=2) with pause1 toggling -> ch0 pulses every 4 cycles, unaffected by ch1; 300 pulses on ch0 -> pulse_cnt0 wraps to 44.

Source files
------------

// File: rtl/multi_rate_timer.sv
// multi_rate_timer
// ----------------
// A bank of CHANNELS independent programmable period timers. It replaces the
// old single flash-rate timer. The control FSM loads and pauses channels. The
// colour-flash logic and the input-timeout logic consume the pulses.
//
// Each channel's period is set by a speed code s, which is sampled on load:
//   s <= MAX_SHIFT : P = (CLK_HZ/BASE_HZ) >> s   (each step doubles the rate)
//   s >  MAX_SHIFT : P = FAST_TICKS cycles
// If load is sampled at edge 0, pulse is high in the cycle after edges
// P, 2P, 3P, ... Every pause-high cycle spent in RUN or PAUSED pushes the
// next expiry back by one cycle.
//
// Ports
//   clk        input   clock
//   reset      input   synchronous, active-high reset
//   load       input   [CHANNELS]          start/restart strobe; takes priority
//                                          over pause and over expiry
//   speed      input   [CHANNELS*SPEED_W]  speed code of channel i at
//                                          [i*SPEED_W +: SPEED_W]
//   mode       input   [CHANNELS]          sampled with load: 0 periodic,
//                                          1 one-shot
//   pause      input   [CHANNELS]          level hold; freezes the count
//   pulse      output  [CHANNELS]          one-cycle registered expiry strobe
//   active     output  [CHANNELS]          channel is in RUN or PAUSED
//   pulse_cnt  output  [CHANNELS*8]        per-channel pulse count at
//                                          [i*8 +: 8]; wraps from 255 to 0
//
// Handshake: there is no backpressure. load is a single-edge strobe, and
// pause is a level. pulse is valid for exactly one cycle. A consumer must
// sample it on every edge.
//
// The FSM of each channel can be observed through the g_ch[i].state_q
// hierarchy (IDLE / RUN / PAUSED).

module multi_rate_timer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BASE_HZ    = 1,
  parameter int CHANNELS   = 2,
  parameter int SPEED_W    = 3,
  parameter int MAX_SHIFT  = 4,
  parameter int FAST_TICKS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          load,
  input  logic [CHANNELS*SPEED_W-1:0]  speed,
  input  logic [CHANNELS-1:0]          mode,
  input  logic [CHANNELS-1:0]          pause,
  output logic [CHANNELS-1:0]          pulse,
  output logic [CHANNELS-1:0]          active,
  output logic [CHANNELS*8-1:0]        pulse_cnt
);

  localparam int DIV   = CLK_HZ / BASE_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [31:0] DIV_U  = 32'(DIV);
  localparam logic [31:0] FAST_U = 32'(FAST_TICKS);

  // Elaboration-time sanity checks on the parameter set.
  if ((DIV % (1 << MAX_SHIFT)) != 0) begin : g_err_div
    $error("multi_rate_timer: CLK_HZ/BASE_HZ must be divisible by 2**MAX_SHIFT");
  end
  if ((DIV >> MAX_SHIFT) < 2) begin : g_err_min
    $error("multi_rate_timer: period at MAX_SHIFT must be at least 2 cycles");
  end
  if ((FAST_TICKS < 2) || (FAST_TICKS > DIV)) begin : g_err_fast
    $error("multi_rate_timer: FAST_TICKS must be in 2 .. CLK_HZ/BASE_HZ");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  // Returns the reload value P(s)-1. The subtraction is done in 32 bits
  // before the result is narrowed. P(0) can equal 2**CNT_W, which would
  // truncate to zero if it were narrowed first.
  function automatic logic [CNT_W-1:0] period_m1(input logic [SPEED_W-1:0] s);
    logic [31:0] p;
    logic [31:0] pm1;
    if (int'(s) <= MAX_SHIFT) begin
      p = DIV_U >> s;
    end else begin
      p = FAST_U;
    end
    pm1 = p - 32'd1;
    return pm1[CNT_W-1:0];
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SPEED_W-1:0] spd_q, spd_d;
    logic               mode_q, mode_d;
    logic               pulse_q, pulse_d;
    logic [7:0]         pcnt_q, pcnt_d;
    logic [SPEED_W-1:0] spd_in;

    assign spd_in = speed[i*SPEED_W +: SPEED_W];

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        spd_q   <= '0;
        mode_q  <= 1'b0;
        pulse_q <= 1'b0;
        pcnt_q  <= 8'd0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        spd_q   <= spd_d;
        mode_q  <= mode_d;
        pulse_q <= pulse_d;
        pcnt_q  <= pcnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      spd_d   = spd_q;
      mode_d  = mode_q;
      pulse_d = 1'b0;
      pcnt_d  = pcnt_q;

      if (load[i]) begin
        // A restart wins over everything else, including a pending expiry
        // on this same edge.
        state_d = RUN;
        cnt_d   = period_m1(spd_in);
        spd_d   = spd_in;
        mode_d  = mode[i];
        pcnt_d  = 8'd0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // IDLE holds its count and ignores pause.
          end
          RUN, PAUSED: begin
            if (pause[i]) begin
              state_d = PAUSED;
            end else begin
              // Once pause drops, this edge counts again. As a result,
              // only the cycles with pause high add delay.
              state_d = RUN;
              if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
              end else begin
                pulse_d = 1'b1;
                pcnt_d  = pcnt_q + 8'd1;
                if (mode_q) begin
                  state_d = IDLE;
                end else begin
                  cnt_d = period_m1(spd_q);
                end
              end
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end

    assign pulse[i]           = pulse_q;
    assign active[i]          = (state_q == RUN) || (state_q == PAUSED);
    assign pulse_cnt[i*8 +: 8] = pcnt_q;

  end

endmodule

// File: tb/tb_multi_rate_timer.sv
// Testbench for multi_rate_timer. It uses CLK_HZ=64, BASE_HZ=1,
// MAX_SHIFT=4 and FAST_TICKS=2, so periods are 64/32/16/8/4 and codes 5-7
// give 2 cycles.
//
// The reference model tracks each channel as an absolute expiry deadline
// measured in edges. A load sets deadline = now + P. Each pause-high edge
// while the channel is armed moves the deadline later by one. An unpaused
// edge that equals the deadline fires. The stimulus pushes the expected
// {pulse, active, pulse_cnt} for every edge. The monitor pops one entry and
// compares it after each rising edge.

module tb_multi_rate_timer;

  localparam int CH = 2;
  localparam int SW = 3;
  localparam int W  = CH * 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     load;
  logic [CH*SW-1:0]  speed;
  logic [CH-1:0]     mode;
  logic [CH-1:0]     pause;
  logic [CH-1:0]     pulse;
  logic [CH-1:0]     active;
  logic [CH*8-1:0]   pulse_cnt;

  multi_rate_timer #(
    .CLK_HZ(64), .BASE_HZ(1), .CHANNELS(CH), .SPEED_W(SW),
    .MAX_SHIFT(4), .FAST_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .speed(speed), .mode(mode),
    .pause(pause), .pulse(pulse), .active(active), .pulse_cnt(pulse_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    reset = 1'b1;
    load  = '0;
    speed = '0;
    mode  = '0;
    pause = '0;
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // reference model state
  bit m_armed[CH];
  bit m_one[CH];
  int m_per[CH];
  int m_dl[CH];
  int m_cnt[CH];
  bit m_pulse[CH];
  int t = 0;

  function automatic int period_of(input int s);
    if (s <= 4) return 64 / (1 << s);
    return 2;
  endfunction

  // driver: drive one edge's inputs, advance the model, push expectation
  task automatic step(input bit rst, input logic [1:0] ld, input logic [5:0] spd,
                      input logic [1:0] md, input logic [1:0] ps);
    logic [1:0]  ep;
    logic [1:0]  ea;
    logic [15:0] ec;
    @(negedge clk);
    reset = rst;
    load  = ld;
    speed = spd;
    mode  = md;
    pause = ps;
    t++;
    for (int c = 0; c < CH; c++) begin
      m_pulse[c] = 1'b0;
      if (rst) begin
        m_armed[c] = 1'b0;
        m_cnt[c]   = 0;
      end else if (ld[c]) begin
        m_armed[c] = 1'b1;
        m_one[c]   = md[c];
        m_per[c]   = period_of(int'(spd[c*3 +: 3]));
        m_dl[c]    = t + m_per[c];
        m_cnt[c]   = 0;
      end else if (m_armed[c]) begin
        if (ps[c]) begin
          m_dl[c]++;
        end else if (t == m_dl[c]) begin
          m_pulse[c] = 1'b1;
          m_cnt[c]   = (m_cnt[c] + 1) % 256;
          if (m_one[c]) m_armed[c] = 1'b0;
          else          m_dl[c] = t + m_per[c];
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      ep[c]         = m_pulse[c];
      ea[c]         = m_armed[c];
      ec[c*8 +: 8]  = 8'(m_cnt[c]);
    end
    exp_q.push_back({ep, ea, ec});
  endtask

  task automatic idle_steps(input int n, input logic [1:0] ps);
    for (int k = 0; k < n; k++)
      step(1'b0, 2'b00, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), ps);
  endtask

  // Directed check of a value after an edge, against a constant taken from
  // the test plan.
  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // monitor: pop and compare after every rising edge
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pulse, active, pulse_cnt};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got pulse=%b active=%b cnt=%h expected pulse=%b active=%b cnt=%h",
                   $time, got[W-1 -: 2], got[W-3 -: 2], got[15:0],
                   e[W-1 -: 2], e[W-3 -: 2], e[15:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    // 1: reset, then 200 idle cycles with no load
    step(1'b1, 2'b00, 6'd0, 2'b00, 2'b00);
    step(1'b1, 2'b00, 6'd0, 2'b00, 2'b00);
    idle_steps(200, 2'b11);
    @(posedge clk); #1;
    check("idle_active", int'(active), 0);
    check("idle_cnt", int'(pulse_cnt), 0);

    // 2: ch0 speed 0 periodic -> pulses after edges 64, 128, 192
    step(1'b1, 2'b00, 6'd0, 2'b00, 2'b00);
    step(1'b0, 2'b01, 6'd0, 2'b00, 2'b00);
    idle_steps(200, 2'b00);
    @(posedge clk); #1;
    check("periodic_cnt0", int'(pulse_cnt[7:0]), 3);
    check("periodic_active0", int'(active[0]), 1);

    // 3: ch1 speed 3 one-shot -> single pulse after edge 8
    step(1'b1, 2'b00, 6'd0, 2'b00, 2'b00);
    step(1'b0, 2'b10, 6'b011_000, 2'b10, 2'b00);
    idle_steps(100, 2'b00);
    @(posedge clk); #1;
    check("oneshot_cnt1", int'(pulse_cnt[15:8]), 1);
    check("oneshot_active1", int'(active[1]), 0);

    // 4: ch0 speed 2, pause high on edges 5..14 -> pulses after 26 and 42
    step(1'b1, 2'b00, 6'd0, 2'b00, 2'b00);
    step(1'b0, 2'b01, 6'd2, 2'b00, 2'b00);
    idle_steps(4, 2'b00);
    idle_steps(10, 2'b01);
    idle_steps(36, 2'b00);
    @(posedge clk); #1;
    check("pause_cnt0", int'(pulse_cnt[7:0]), 2);

    // 5: ch0 speed 1, re-load speed 7 on the expiry edge 32, reset at 37
    step(1'b1, 2'b00, 6'd0, 2'b00, 2'b00);
    step(1'b0, 2'b01, 6'd1, 2'b00, 2'b00);
    idle_steps(31, 2'b00);
    step(1'b0, 2'b01, 6'd7, 2'b00, 2'b00);
    idle_steps(4, 2'b00);
    @(posedge clk); #1;
    check("reload_cnt0", int'(pulse_cnt[7:0]), 2);
    step(1'b1, 2'b00, 6'd7, 2'b00, 2'b00);
    @(posedge clk); #1;
    check("reset_pulse", int'(pulse), 0);
    check("reset_active", int'(active), 0);
    check("reset_cnt", int'(pulse_cnt), 0);
    idle_steps(10, 2'b00);

    // 6: both channels loaded, pause1 toggling, 300 ch0 pulses -> 44
    step(1'b0, 2'b11, 6'b010_100, 2'b00, 2'b00);
    for (int k = 0; k < 1200; k++)
      step(1'b0, 2'b00, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
           {1'($urandom_range(0, 1)), 1'b0});
    @(posedge clk); #1;
    check("wrap_cnt0", int'(pulse_cnt[7:0]), 44);

    // random phase
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 299) == 0,
           {$urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0},
           6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
           {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
    end

    // final report
    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
